// File: rtl/sw_input_conditioner.sv
// Switch input conditioner. Each bit is synchronised through two flops, then debounced independently.
// It produces a stable level and one-cycle rise/fall pulses.
module sw_input_conditioner #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Tick_en,
  input  logic [WIDTH-1:0] SW_raw,
  output logic [WIDTH-1:0] SW_out,
  output logic [WIDTH-1:0] SW_rise,
  output logic [WIDTH-1:0] SW_fall,
  output logic             SW_changed
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync_p0;
  logic [WIDTH-1:0] r_sync_p1;
  logic [WIDTH-1:0] r_stable_p2;
  logic [WIDTH-1:0] r_rise_p2;
  logic [WIDTH-1:0] r_fall_p2;
  logic [CNT_W-1:0] r_cnt_p2 [WIDTH];

  // Stages p0/p1: two-flop synchroniser
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= SW_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Stage p2: per-bit debounce; a match with the stable level always restarts the window
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stable_p2 <= '0;
      r_rise_p2   <= '0;
      r_fall_p2   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_rise_p2[i] <= 1'b0;
        r_fall_p2[i] <= 1'b0;
        if (r_sync_p1[i] == r_stable_p2[i]) begin
          r_cnt_p2[i] <= '0;
        end else if (Tick_en) begin
          if (r_cnt_p2[i] == LAST_CNT) begin
            r_stable_p2[i] <= r_sync_p1[i];
            r_cnt_p2[i]    <= '0;
            r_rise_p2[i]   <= r_sync_p1[i];
            r_fall_p2[i]   <= ~r_sync_p1[i];
          end else begin
            r_cnt_p2[i] <= r_cnt_p2[i] + 1'b1;
          end
        end
      end
    end
  end

  assign SW_out     = r_stable_p2;
  assign SW_rise    = r_rise_p2;
  assign SW_fall    = r_fall_p2;
  assign SW_changed = |(r_rise_p2 | r_fall_p2);

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Self-checking bench for sw_input_conditioner: a behavioural model compared every cycle,
// directed scenarios with literal expectations, and randomized stimulus.
module tb_sw_input_conditioner;
  localparam int W = 5;
  localparam int D = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Tick_en = 1'b1;
  logic [W-1:0] SW_raw = '0;
  logic [W-1:0] SW_out, SW_rise, SW_fall;
  logic         SW_changed;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  sw_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Tick_en(Tick_en), .SW_raw(SW_raw),
    .SW_out(SW_out), .SW_rise(SW_rise), .SW_fall(SW_fall), .SW_changed(SW_changed)
  );

  always #5 Clk = ~Clk;

  // Reference: the raw input is seen two samples late. A bit is accepted once D
  // qualified samples in a row disagree with the current level.
  logic [W-1:0] m_d1 = '0, m_d2 = '0, m_out = '0, m_rise = '0, m_fall = '0;
  int           m_run [W];

  initial for (int i = 0; i < W; i++) m_run[i] = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_d1 = '0; m_d2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_d2[i] == m_out[i]) m_run[i] = 0;
        else if (Tick_en) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= D) begin
            m_out[i]  = m_d2[i];
            m_rise[i] = m_d2[i];
            m_fall[i] = ~m_d2[i];
            m_run[i]  = 0;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = SW_raw;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      n_checks += 4;
      if (SW_out !== m_out) begin
        n_fail++; $display("FAIL cyc_out t=%0t actual=%b required=%b", $time, SW_out, m_out);
      end
      if (SW_rise !== m_rise) begin
        n_fail++; $display("FAIL cyc_rise t=%0t actual=%b required=%b", $time, SW_rise, m_rise);
      end
      if (SW_fall !== m_fall) begin
        n_fail++; $display("FAIL cyc_fall t=%0t actual=%b required=%b", $time, SW_fall, m_fall);
      end
      if (SW_changed !== |(m_rise | m_fall)) begin
        n_fail++; $display("FAIL cyc_changed t=%0t actual=%b required=%b", $time, SW_changed, |(m_rise | m_fall));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Checks the DUT and pins the reference model against the same literal value
  task automatic chk_out(input string name, input logic [W-1:0] exp);
    chk({name, "_dut"}, SW_out, exp);
    chk({name, "_model"}, m_out, exp);
  endtask

  initial begin
    // Reset then idle with all switches high
    SW_raw = 5'b11111; Reset = 1'b1; Tick_en = 1'b1;
    step(1); cmp_en = 1'b1;
    step(1);
    chk_out("reset_out", 5'b00000);
    chk("reset_rise", SW_rise, 5'b00000);
    chk("reset_chg", {4'b0, SW_changed}, 5'b00000);
    Reset = 1'b0;
    step(5); chk_out("rel_edge5", 5'b00000);
    step(1); chk_out("rel_edge6", 5'b11111);
    chk("rel_rise", SW_rise, 5'b11111);
    chk("rel_chg", {4'b0, SW_changed}, 5'b00001);
    step(1); chk("rel_rise_end", SW_rise, 5'b00000);
    chk("rel_chg_end", {4'b0, SW_changed}, 5'b00000);

    SW_raw = 5'b00000; step(8); chk_out("all_low", 5'b00000);

    // Short glitch is rejected, 5-cycle pulse is accepted
    SW_raw = 5'b00100; step(3); SW_raw = 5'b00000; step(8);
    chk_out("glitch3", 5'b00000);
    SW_raw = 5'b00100; step(5); SW_raw = 5'b00000; step(1);
    chk_out("pulse5", 5'b00100);
    chk("pulse5_rise", SW_rise, 5'b00100);
    SW_raw = 5'b00100; step(8);

    // Fall edge
    SW_raw = 5'b00000; step(5); chk_out("fall_e4", 5'b00100);
    step(1); chk_out("fall_e5", 5'b00000);
    chk("fall_pulse", SW_fall, 5'b00100);
    chk("fall_norise", SW_rise, 5'b00000);
    SW_raw = 5'b00100; step(8);

    // Tick gating extends latency by the gated edges
    SW_raw = 5'b00101; step(3); Tick_en = 1'b0; step(3); Tick_en = 1'b1;
    step(2); chk_out("tick_e7", 5'b00100);
    step(1); chk_out("tick_e8", 5'b00101);
    chk("tick_rise", SW_rise, 5'b00001);
    step(4);
    // Mismatch ending while gated must still restart the window
    SW_raw = 5'b00100; step(4); Tick_en = 1'b0; SW_raw = 5'b00101; step(6);
    Tick_en = 1'b1; SW_raw = 5'b00100;
    step(5); chk_out("clr_e4", 5'b00101);
    step(1); chk_out("clr_e5", 5'b00100);
    chk("clr_fall", SW_fall, 5'b00001);
    step(4);

    // Reset mid-window discards the partial count and the stable level
    SW_raw = 5'b10100; step(3); Reset = 1'b1; step(1); Reset = 1'b0;
    chk_out("rstmid", 5'b00000);
    step(5); chk_out("rstmid_e5", 5'b00000);
    step(1); chk_out("rstmid_e6", 5'b10100);
    chk("rstmid_rise", SW_rise, 5'b10100);
    step(4);

    // Independent bits, staggered then together
    SW_raw = 5'b10110; step(2); SW_raw = 5'b11110;
    step(3); chk("ind_e4", SW_rise, 5'b00000);
    step(1); chk("ind_e5", SW_rise, 5'b00010);
    step(1); chk("ind_e6", SW_rise, 5'b00000);
    step(1); chk("ind_e7", SW_rise, 5'b01000);
    SW_raw = 5'b10100; step(8);
    SW_raw = 5'b11110; step(5); chk("both_e4", SW_rise, 5'b00000);
    step(1); chk("both_e5", SW_rise, 5'b01010);
    chk_out("both_out", 5'b11110);

    // Randomized traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) SW_raw = W'($urandom);
      Tick_en = ($urandom_range(0, 3) != 0);
      Reset   = ($urandom_range(0, 299) == 0);
      step(1);
    end
    Reset = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
